// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: storage mux, same-cycle write bypass and zero-register masking.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  rf_state_t                  state,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [DATA_W-1:0]          mem [2**ADDR_W],
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]          rd_data
);

  logic              hit;
  logic [DATA_W-1:0] byp_data;

  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    rd_data  = '0;
    // Later ports overwrite earlier matches, so the highest-index writer wins.
    for (int w = 0; w < NUM_WR; w++) begin
      if (we[w] && wr_addr[w*ADDR_W +: ADDR_W] == rd_addr) begin
        hit      = 1'b1;
        byp_data = wr_data[w*DATA_W +: DATA_W];
      end
    end
    if (state == RUN && !(ZERO_REG != 0 && rd_addr == '0)) begin
      rd_data = (BYPASS != 0 && hit) ? byp_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write priority, optional bypass/zero register,
// and a sequential clear engine that walks every entry after reset or on request.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  input  logic [NUM_WR-1:0]          we_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic                       clear_i,
  output logic                       busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  rf_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              busy_reg, busy_next;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    busy_next    = busy_reg;
    if (state_reg == CLEAR) begin
      clr_cnt_next = clr_cnt_reg + 1'b1;
      if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
        state_next = RUN;
        busy_next  = 1'b0;
      end
    end else if (clear_i) begin
      state_next   = CLEAR;
      clr_cnt_next = '0;
      busy_next    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      busy_reg    <= busy_next;
    end
  end

  // Storage has no reset; the clear engine is what makes contents defined.
  // In RUN the last assignment in port order takes effect, giving higher ports priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem_reg[clr_cnt_reg] <= '0;
      end else begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (we_i[w] && !(ZERO_REG != 0 && wr_addr_i[w*ADDR_W +: ADDR_W] == '0)) begin
            mem_reg[wr_addr_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
      ) u_rd (
        .state   (state_reg),
        .rd_addr (rd_addr_i[gi*ADDR_W +: ADDR_W]),
        .mem     (mem_reg),
        .we      (we_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_data (rd_data_o[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign busy_o = busy_reg;

endmodule
